// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// Every RAM-side output is decoded from registered state, so request inputs never reach the RAM combinationally.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_A,
  input  logic                  REQ_B,
  input  logic                  WE_A,
  input  logic                  WE_B,
  input  logic [ADDR_WIDTH-1:0] ADDR_A,
  input  logic [ADDR_WIDTH-1:0] ADDR_B,
  input  logic [DATA_WIDTH-1:0] DIN_A,
  input  logic [DATA_WIDTH-1:0] DIN_B,
  output logic                  ACK_A,
  output logic                  ACK_B,
  output logic [DATA_WIDTH-1:0] DOUT_A,
  output logic [DATA_WIDTH-1:0] DOUT_B,
  output logic                  BUSY,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, ACK} state_e;

  state_e                state_q, state_d;
  logic                  win_b_q, win_b_d;
  logic                  last_b_q, last_b_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
  logic [DATA_WIDTH-1:0] dout_b_q, dout_b_d;
  logic                  grant_b;

  always_comb begin
    state_d  = state_q;
    win_b_d  = win_b_q;
    last_b_d = last_b_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    // B wins when it is alone, or when both ask and A was served last
    grant_b  = REQ_B && (!REQ_A || !last_b_q);
    case (state_q)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          win_b_d = grant_b;
          we_d    = grant_b ? WE_B   : WE_A;
          addr_d  = grant_b ? ADDR_B : ADDR_A;
          din_d   = grant_b ? DIN_B  : DIN_A;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = we_q ? ACK : RDATA;
      RDATA: begin
        if (win_b_q) dout_b_d = RAM_DOUT;
        else         dout_a_d = RAM_DOUT;
        state_d = ACK;
      end
      ACK: begin
        last_b_d = win_b_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      win_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      state_q  <= state_d;
      win_b_q  <= win_b_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign RAM_EN   = (state_q == ACCESS) || (state_q == RDATA);
  assign RAM_WE   = (state_q == ACCESS) && we_q;
  assign RAM_ADDR = addr_q;
  assign RAM_DIN  = din_q;
  assign BUSY     = (state_q != IDLE);
  assign ACK_A    = (state_q == ACK) && !win_b_q;
  assign ACK_B    = (state_q == ACK) && win_b_q;
  assign DOUT_A   = dout_a_q;
  assign DOUT_B   = dout_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: cycle-by-cycle vector table against a behavioural RAM, plus a
// hand-written continuous-contention sequence checking strict alternation.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, req_a, req_b, we_a, we_b;
  logic [7:0] addr_a, addr_b, ram_addr;
  logic [9:0] din_a, din_b, dout_a, dout_b, ram_din;
  logic       ack_a, ack_b, busy, ram_en, ram_we;
  wire  [9:0] ram_dout;

  logic [9:0] mem [256];
  logic [9:0] ram_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(10)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_A(req_a), .REQ_B(req_b), .WE_A(we_a), .WE_B(we_b),
    .ADDR_A(addr_a), .ADDR_B(addr_b), .DIN_A(din_a), .DIN_B(din_b),
    .ACK_A(ack_a), .ACK_B(ack_b), .DOUT_A(dout_a), .DOUT_B(dout_b),
    .BUSY(busy), .RAM_EN(ram_en), .RAM_WE(ram_we),
    .RAM_ADDR(ram_addr), .RAM_DIN(ram_din), .RAM_DOUT(ram_dout)
  );

  // single-port RAM with registered read and tri-stated output
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_q <= mem[ram_addr];
    end
  end
  assign ram_dout = (ram_en && !ram_we) ? ram_q : 10'bz;

  typedef struct {
    string      name;
    logic       rst_n, req_a, we_a;
    logic [7:0] addr_a;
    logic [9:0] din_a;
    logic       req_b, we_b;
    logic [7:0] addr_b;
    logic [9:0] din_b;
    logic       ack_a, ack_b, busy, en, we;
    logic [7:0] raddr;
    logic [9:0] dout_a, dout_b;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic r,
                     input logic ra, input logic wa, input logic [7:0] aa, input logic [9:0] da,
                     input logic rb, input logic wb, input logic [7:0] ab, input logic [9:0] db,
                     input logic xa, input logic xb, input logic bz, input logic en, input logic we,
                     input logic [7:0] radr, input logic [9:0] oa, input logic [9:0] ob);
    vec_t v;
    v.name = nm; v.rst_n = r;
    v.req_a = ra; v.we_a = wa; v.addr_a = aa; v.din_a = da;
    v.req_b = rb; v.we_b = wb; v.addr_b = ab; v.din_b = db;
    v.ack_a = xa; v.ack_b = xb; v.busy = bz; v.en = en; v.we = we;
    v.raddr = radr; v.dout_a = oa; v.dout_b = ob;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;

    //   name         rst reqA weA addrA  dinA   reqB weB addrB dinB  ackA ackB busy en we raddr doutA  doutB
    add("rst",         0, 0,0,8'h00,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h000);
    add("wa_acc",      1, 1,1,8'h12,10'h155, 0,0,8'h00,10'h0, 0,0,1,1,1,8'h12,10'h000,10'h000);
    add("wa_ack",      1, 1,1,8'h12,10'h155, 0,0,8'h00,10'h0, 1,0,1,0,0,8'h12,10'h000,10'h000);
    add("wa_idle",     1, 0,0,8'h00,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h000);
    add("rb_acc",      1, 0,0,8'h00,10'h000, 1,0,8'h12,10'h0, 0,0,1,1,0,8'h12,10'h000,10'h000);
    add("rb_rdata",    1, 0,0,8'h00,10'h000, 1,0,8'h12,10'h0, 0,0,1,1,0,8'h12,10'h000,10'h000);
    add("rb_ack",      1, 0,0,8'h00,10'h000, 1,0,8'h12,10'h0, 0,1,1,0,0,8'h12,10'h000,10'h155);
    add("rb_idle",     1, 0,0,8'h00,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h155);
    add("rst2",        0, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h000);
    add("sim_a_acc",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,0,1,1,1,8'h01,10'h000,10'h000);
    add("sim_a_ack",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 1,0,1,0,0,8'h01,10'h000,10'h000);
    add("sim_idle1",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,0,0,0,0,8'h01,10'h000,10'h000);
    add("sim_b_acc",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,0,1,1,0,8'h01,10'h000,10'h000);
    add("sim_b_rd",    1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,0,1,1,0,8'h01,10'h000,10'h000);
    add("sim_b_ack",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,1,1,0,0,8'h01,10'h000,10'h3FF);
    add("sim_idle2",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,0,0,0,0,8'h01,10'h000,10'h3FF);
    add("rep_a_acc",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 0,0,1,1,1,8'h01,10'h000,10'h3FF);
    add("rep_a_ack",   1, 1,1,8'h01,10'h3FF, 1,0,8'h01,10'h0, 1,0,1,0,0,8'h01,10'h000,10'h3FF);
    add("rep_idle",    1, 0,0,8'h00,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h3FF);
    add("ra_acc",      1, 1,0,8'h12,10'h000, 0,0,8'h00,10'h0, 0,0,1,1,0,8'h12,10'h000,10'h3FF);
    add("ra_rdata",    1, 1,0,8'h12,10'h000, 0,0,8'h00,10'h0, 0,0,1,1,0,8'h12,10'h000,10'h3FF);
    add("ra_rst",      0, 1,0,8'h12,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h000);
    add("ra2_acc",     1, 1,0,8'h12,10'h000, 0,0,8'h00,10'h0, 0,0,1,1,0,8'h12,10'h000,10'h000);
    add("ign_rdata",   1, 1,0,8'h20,10'h000, 0,0,8'h00,10'h0, 0,0,1,1,0,8'h12,10'h000,10'h000);
    add("ign_ack",     1, 1,0,8'h20,10'h000, 0,0,8'h00,10'h0, 1,0,1,0,0,8'h12,10'h155,10'h000);
    add("ign_idle",    1, 0,0,8'h00,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h155,10'h000);
    add("rw_acc",      1, 1,1,8'h33,10'h0AA, 0,0,8'h00,10'h0, 0,0,1,1,1,8'h33,10'h155,10'h000);
    add("rw_rst",      0, 1,1,8'h33,10'h0AA, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h000);
    add("rw_idle",     1, 0,0,8'h00,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h000);
    add("r33_acc",     1, 0,0,8'h00,10'h000, 1,0,8'h33,10'h0, 0,0,1,1,0,8'h33,10'h000,10'h000);
    add("r33_rd",      1, 0,0,8'h00,10'h000, 1,0,8'h33,10'h0, 0,0,1,1,0,8'h33,10'h000,10'h000);
    add("r33_ack",     1, 0,0,8'h00,10'h000, 1,0,8'h33,10'h0, 0,1,1,0,0,8'h33,10'h000,10'h0AA);
    add("r33_idle",    1, 0,0,8'h00,10'h000, 0,0,8'h00,10'h0, 0,0,0,0,0,8'h00,10'h000,10'h0AA);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      req_a = vq[i].req_a; we_a = vq[i].we_a; addr_a = vq[i].addr_a; din_a = vq[i].din_a;
      req_b = vq[i].req_b; we_b = vq[i].we_b; addr_b = vq[i].addr_b; din_b = vq[i].din_b;
      @(posedge clk); #1;
      chk({vq[i].name, ".ack_a"},  ack_a,  vq[i].ack_a);
      chk({vq[i].name, ".ack_b"},  ack_b,  vq[i].ack_b);
      chk({vq[i].name, ".busy"},   busy,   vq[i].busy);
      chk({vq[i].name, ".ram_en"}, ram_en, vq[i].en);
      chk({vq[i].name, ".ram_we"}, ram_we, vq[i].we);
      if (vq[i].en) chk({vq[i].name, ".ram_addr"}, ram_addr, vq[i].raddr);
      chk({vq[i].name, ".dout_a"}, dout_a, vq[i].dout_a);
      chk({vq[i].name, ".dout_b"}, dout_b, vq[i].dout_b);
    end

    // both requesters held high: grants must alternate starting with A
    begin
      logic exp_b;
      int   n_ack, low_run;
      exp_b = 1'b0; n_ack = 0; low_run = 0;
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h40; din_a = 10'h2A5;
      req_b = 1'b1; we_b = 1'b0; addr_b = 8'h40; din_b = 10'h000;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        chk("cont.overlap", ack_a & ack_b, 0);
        if (ack_a || ack_b) begin
          chk("cont.rr_order", ack_b, exp_b);
          exp_b = ~exp_b;
          n_ack++;
        end
        if (!busy) low_run++;
        else begin
          if (low_run != 0) chk("cont.busy_gap", low_run, 1);
          low_run = 0;
        end
      end
      chk("cont.ack_count", n_ack, 6);
      chk("cont.dout_b", dout_b, 10'h2A5);
    end

    req_a = 1'b0; req_b = 1'b0;
    begin
      int waited;
      waited = 0;
      do begin
        @(posedge clk); #1;
        waited++;
      end while (busy && waited < 8);
      chk("drain.busy", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
